// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator producing scan coordinates, syncs, blank and line/frame strobes.
// Ports: vclock (pixel clock), reset (async, active-high), hcount[10:0], vcount[9:0],
//        hsync, vsync, blank, line_start, frame_start -- all driven straight from flops.
// Macro VTG_SYNC_POSITIVE_EN: defined -> active-high syncs; undefined -> active-low syncs.
module video_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic        vclock,
  input  logic        reset,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  // Decode bounds are one bit wider than the counters so a window ending at 2048/1024 still compares correctly.
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_ON  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_ON  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VTG_SYNC_POSITIVE_EN
  localparam logic SYNC_ON = 1'b1;
`else
  localparam logic SYNC_ON = 1'b0;
`endif
  logic [10:0] r_hcount;
  logic [9:0]  r_vcount;
  logic        r_hsync, r_vsync, r_blank, r_line_start, r_frame_start;
  logic        w_hwrap, w_vwrap;
  logic [10:0] w_hnext;
  logic [9:0]  w_vnext;
  logic [11:0] w_hn;
  logic [10:0] w_vn;
  assign w_hwrap = r_hcount == H_LAST;
  assign w_vwrap = w_hwrap && r_vcount == V_LAST;
  assign w_hnext = w_hwrap ? 11'd0 : r_hcount + 11'd1;
  assign w_vnext = w_vwrap ? 10'd0 : w_hwrap ? r_vcount + 10'd1 : r_vcount;
  assign w_hn    = {1'b0, w_hnext};
  assign w_vn    = {1'b0, w_vnext};
  // Decodes use the next-state coordinates so every registered output matches the registered counters.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= ~SYNC_ON;
      r_vsync       <= ~SYNC_ON;
      r_blank       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= w_hnext;
      r_vcount      <= w_vnext;
      r_hsync       <= (w_hn >= HS_ON && w_hn < HS_OFF) ? SYNC_ON : ~SYNC_ON;
      r_vsync       <= (w_vn >= VS_ON && w_vn < VS_OFF) ? SYNC_ON : ~SYNC_ON;
      r_blank       <= w_hn >= H_ACT || w_vn >= V_ACT;
      r_line_start  <= w_hwrap;
      r_frame_start <= w_vwrap;
    end
  end
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: checks default and small-parameter timing generators against a cycle-count model.
module tb_video_timing_gen;
`ifdef VTG_SYNC_POSITIVE_EN
  localparam logic SA = 1'b1;
`else
  localparam logic SA = 1'b0;
`endif
  logic vclock = 1'b0;
  always #5 vclock = ~vclock;
  logic rst_d = 1'b1, rst_s = 1'b1;
  logic [10:0] hc_d, hc_s;
  logic [9:0]  vc_d, vc_s;
  logic hs_d, vs_d, bl_d, ls_d, fs_d;
  logic hs_s, vs_s, bl_s, ls_s, fs_s;
  int tests = 0, fails = 0;
  int n_d = 0, n_s = 0;
  video_timing_gen dut_d (
    .vclock(vclock), .reset(rst_d), .hcount(hc_d), .vcount(vc_d), .hsync(hs_d), .vsync(vs_d),
    .blank(bl_d), .line_start(ls_d), .frame_start(fs_d)
  );
  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)
  ) dut_s (
    .vclock(vclock), .reset(rst_s), .hcount(hc_s), .vcount(vc_s), .hsync(hs_s), .vsync(vs_s),
    .blank(bl_s), .line_start(ls_s), .frame_start(fs_s)
  );
  // Edges seen since reset was released; the model derives everything from this.
  always @(posedge vclock or posedge rst_d) n_d <= rst_d ? 0 : n_d + 1;
  always @(posedge vclock or posedge rst_s) n_s <= rst_s ? 0 : n_s + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask
  function automatic logic [25:0] model(input int n, input int ha, hf, hs, hb, va, vf, vs, vb);
    int ht = ha + hf + hs + hb;
    int vt = va + vf + vs + vb;
    int h = n % ht;
    int v = (n / ht) % vt;
    logic hsy = (h >= ha + hf && h < ha + hf + hs) ? SA : !SA;
    logic vsy = (v >= va + vf && v < va + vf + vs) ? SA : !SA;
    logic ls = n > 0 && h == 0;
    return {11'(h), 10'(v), hsy, vsy, h >= ha || v >= va, ls, ls && v == 0};
  endfunction
  task automatic cmp(input string nm, input logic [25:0] e, input logic [10:0] hc, input logic [9:0] vc,
                     input logic hs, vs, bl, ls, fs);
    check({nm, ".hcount"}, 32'(hc), 32'(e[25:15]));
    check({nm, ".vcount"}, 32'(vc), 32'(e[14:5]));
    check({nm, ".hsync"}, 32'(hs), 32'(e[4]));
    check({nm, ".vsync"}, 32'(vs), 32'(e[3]));
    check({nm, ".blank"}, 32'(bl), 32'(e[2]));
    check({nm, ".line_start"}, 32'(ls), 32'(e[1]));
    check({nm, ".frame_start"}, 32'(fs), 32'(e[0]));
  endtask
  task automatic check_reset(input string nm, input logic [10:0] hc, input logic [9:0] vc,
                             input logic hs, vs, bl, ls, fs);
    cmp(nm, {21'd0, !SA, !SA, 3'b000}, hc, vc, hs, vs, bl, ls, fs);
  endtask
  int cyc = 0, last_ls = -1, last_fs = -1;
  always @(negedge vclock) begin
    cyc++;
    cmp("d", model(n_d, 1024, 24, 136, 160, 768, 3, 6, 29), hc_d, vc_d, hs_d, vs_d, bl_d, ls_d, fs_d);
    cmp("s", model(n_s, 8, 2, 2, 4, 4, 1, 1, 2), hc_s, vc_s, hs_s, vs_s, bl_s, ls_s, fs_s);
    if (rst_d) last_ls = -1;
    else if (ls_d) begin
      if (last_ls >= 0) check("d.line_period", 32'(cyc - last_ls), 32'd1344);
      last_ls = cyc;
    end
    if (rst_s) last_fs = -1;
    else if (fs_s) begin
      if (last_fs >= 0) check("s.frame_period", 32'(cyc - last_fs), 32'd128);
      last_fs = cyc;
    end
  end
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end
  initial begin
    fork
      begin : seq_d
        repeat (5) @(posedge vclock);
        #1 check_reset("d.rst", hc_d, vc_d, hs_d, vs_d, bl_d, ls_d, fs_d);
        #2 rst_d = 1'b0;
        @(posedge vclock);
        #1 check("d.first_h", 32'(hc_d), 32'd1);
        check("d.first_v", 32'(vc_d), 32'd0);
        repeat (2 * 1344 + 50) @(posedge vclock);
        for (int i = 0; i < 2000 && hc_d != 11'd1100; i++) @(negedge vclock);
        check("d.reach1100", 32'(hc_d), 32'd1100);
        #2 rst_d = 1'b1;
        #1 check_reset("d.async", hc_d, vc_d, hs_d, vs_d, bl_d, ls_d, fs_d);
        repeat (3) @(negedge vclock);
        #2 rst_d = 1'b0;
        @(posedge vclock);
        #1 check("d.restart_h", 32'(hc_d), 32'd1);
        check("d.restart_v", 32'(vc_d), 32'd0);
        repeat (200) @(posedge vclock);
      end
      begin : seq_s
        repeat (3) @(posedge vclock);
        #1 check_reset("s.rst", hc_s, vc_s, hs_s, vs_s, bl_s, ls_s, fs_s);
        #2 rst_s = 1'b0;
        repeat (400) @(posedge vclock);
        for (int k = 0; k < 25; k++) begin
          int d;
          repeat ($urandom_range(1, 300)) @(posedge vclock);
          d = int'($urandom_range(1, 4));
          if (d >= 3) d += 4;
          #(d) rst_s = 1'b1;
          #1 check_reset("s.async", hc_s, vc_s, hs_s, vs_s, bl_s, ls_s, fs_s);
          repeat ($urandom_range(1, 3)) @(posedge vclock);
          #3 rst_s = 1'b0;
          @(posedge vclock);
          #1 check("s.restart_h", 32'(hc_s), 32'd1);
          check("s.restart_v", 32'(vc_s), 32'd0);
        end
        repeat (300) @(posedge vclock);
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator that drives the display pipeline. It produces the `hcount`/`vcount` scan coordinates consumed by the sprite and shape generators, plus `hsync`, `vsync`, `blank` and frame/line strobes for the VGA output stage. All outputs are registered and mutually aligned, so downstream combinational pixel logic sees a coherent coordinate/sync set every cycle. The default parameters give 1024x768 at 60 Hz on a 65 MHz pixel clock.

## Interface
Parameters:
- `H_ACTIVE`, default 1024: visible pixels per line.
- `H_FP`, default 24: horizontal front porch, in pixels.
- `H_SYNC`, default 136: hsync pulse width, in pixels.
- `H_BP`, default 160: horizontal back porch; H_TOTAL = sum of the four horizontal parameters = 1344.
- `V_ACTIVE`, default 768: visible lines.
- `V_FP`, default 3: vertical front porch, in lines.
- `V_SYNC`, default 6: vsync pulse width, in lines.
- `V_BP`, default 29: vertical back porch; V_TOTAL = sum of the four vertical parameters = 806.

Ports:
- `vclock`  in  1: pixel clock. One clock, single domain.
- `reset`  in  1: asynchronous, active-high reset.
- `hcount`  out  11: current pixel column, 0..H_TOTAL-1.
- `vcount`  out  10: current line, 0..V_TOTAL-1.
- `hsync`  out  1: horizontal sync; polarity is set by the configuration macro.
- `vsync`  out  1: vertical sync; polarity is set by the configuration macro.
- `blank`  out  1: high outside the active area.
- `line_start`  out  1: one-cycle pulse while `hcount`==0, entered by wrap.
- `frame_start`  out  1: one-cycle pulse while `hcount`==0 and `vcount`==0, entered by wrap.

## Operation
- Horizontal counter:
  - `hcount` increments every `vclock` cycle.
  - At H_TOTAL-1 it wraps to 0, and `vcount` increments in the same edge.
- Vertical counter:
  - At the edge where `hcount` wraps and `vcount`==V_TOTAL-1, both counters go to 0.
- Decode ranges (sync shown as asserted level):
  - hsync asserted for H_ACTIVE+H_FP <= `hcount` < H_ACTIVE+H_FP+H_SYNC. With defaults: 1048..1183.
  - vsync asserted for V_ACTIVE+V_FP <= `vcount` < V_ACTIVE+V_FP+V_SYNC. With defaults: 771..776, for whole lines only, changing only at `hcount` wrap.
  - `blank` = (`hcount` >= H_ACTIVE) or (`vcount` >= V_ACTIVE).
- Alignment:
  - The decodes are computed from the next-state counter values and registered.
  - Every output therefore describes the same (`hcount`, `vcount`) pair in the same cycle, with zero relative skew.
- Strobes:
  - `line_start` is high exactly in cycles where `hcount`==0 following a wrap.
  - `frame_start` is high exactly when both counters are 0 following a frame wrap.
- Width rules:
  - H_TOTAL must be <= 2048 and V_TOTAL <= 1024.
  - The comparisons are unsigned at full counter width; counters never exceed TOTAL-1.
- Reset:
  - While `reset` is high: `hcount`=0, `vcount`=0, `blank`=0, `line_start`=0, `frame_start`=0, and `hsync`/`vsync` deasserted.
  - Asserting `reset` mid-line or mid-frame forces these values immediately (asynchronously). There is no partial-frame recovery.

## Timing
- Latency:
  - After `reset` falls, the first `vclock` rising edge shows `hcount`=1, `vcount`=0.
  - Coordinate (0,0) is next shown after a full frame, H_TOTAL*V_TOTAL cycles, with `frame_start`=1.
- Periods:
  - `line_start` period is exactly H_TOTAL cycles.
  - `frame_start` period is exactly H_TOTAL*V_TOTAL cycles; with defaults that is 1,083,264.
- Simultaneous line and frame wrap:
  - `line_start` and `frame_start` are both high in that cycle.
  - vsync/blank update on that same edge.
- No glitches: every output comes directly from a flop.

## Configuration
- `VTG_SYNC_POSITIVE_EN`:
  - Defined: `hsync`/`vsync` are active-high; the deasserted (reset) level is 0.
  - Undefined (default): both are active-low, as standard VESA 1024x768; the deasserted (reset) level is 1.
- `blank` polarity and all counter behaviour are unaffected by the macro.

## Test plan
- Reset value check:
  - Stimulus: hold `reset` for 5 cycles with defaults and the macro undefined.
  - Required: `hcount`=0, `vcount`=0, `hsync`=1, `vsync`=1, `blank`=0, both strobes 0.
  - Stimulus: release `reset`. Required: the first edge gives `hcount`=1.
- Line decode:
  - Required: `blank` rises at `hcount`=1024; `hsync` is 0 for `hcount` 1048..1183 and 1 at 1184.
  - Required: at `hcount` 1343→0, `vcount` increments and `line_start`=1 for one cycle.
- Frame wrap:
  - Stimulus: run to `vcount`=805, `hcount`=1343.
  - Required: the next cycle gives (0,0) with `frame_start`=1 and `line_start`=1.
  - Required: `vsync`=0 exactly on lines 771..776.
- Mid-frame reset:
  - Stimulus: assert `reset` asynchronously at (500,300), between clock edges.
  - Required: outputs go to reset values before the next edge; after release, counting restarts from (1,0).
- Macro polarity:
  - Stimulus: build with `VTG_SYNC_POSITIVE_EN` defined.
  - Required: sync reset level is 0, and `hsync`=1 only for `hcount` 1048..1183.
- Small parameters:
  - Stimulus: H 8/2/2/4 and V 4/1/1/2.
  - Required: `frame_start` every 128 cycles; the `hsync` window is `hcount` 10..11; the `vsync` window is `vcount` 5.
